// File: rtl/ecc_pkg.sv
// Shared types and defaults for the elliptic-curve scalar-multiplication datapath.
package ecc_pkg;

  localparam int unsigned KEY_W_DEF  = 256;
  localparam int unsigned DATA_W_DEF = 256;

  // Point at infinity is encoded by an all-ones x coordinate.
  localparam logic [DATA_W_DEF-1:0] INF_X = '1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DBL_REQ,
    ST_DBL_WAIT,
    ST_ADD_CHK,
    ST_ADD_REQ,
    ST_ADD_WAIT,
    ST_NEXT,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] x;
    logic [DATA_W_DEF-1:0] y;
  } point_t;

endpackage

// File: rtl/ecc_point_cmp.sv
// Combinational classification of accumulator Q against base point G.
module ecc_point_cmp
  import ecc_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] q_x_i,
  input  logic [DATA_W-1:0] q_y_i,
  input  logic [DATA_W-1:0] g_x_i,
  input  logic [DATA_W-1:0] g_y_i,
  output logic              is_inf_o,
  output logic              same_x_o,
  output logic              same_y_o
);

  assign is_inf_o = (q_x_i == {DATA_W{1'b1}});
  assign same_x_o = (q_x_i == g_x_i);
  assign same_y_o = (q_y_i == g_y_i);

endmodule

// File: rtl/scalar_mult_ctrl.sv
// MSB-first double-and-add sequencer driving external point-double and point-add engines.
// Define SCALAR_MULT_CONST_TIME_EN for a k-independent engine call sequence (no leading-zero skip, dummy adds).
module scalar_mult_ctrl
  import ecc_pkg::*;
#(
  parameter int unsigned KEY_W  = KEY_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [KEY_W-1:0]  i_k,
  input  logic [DATA_W-1:0] i_gx,
  input  logic [DATA_W-1:0] i_gy,
  output logic              o_busy,
  output logic              o_finished,
  output logic [DATA_W-1:0] o_rx,
  output logic [DATA_W-1:0] o_ry,
  output logic              o_dbl_start,
  output logic [DATA_W-1:0] o_dbl_x,
  output logic [DATA_W-1:0] o_dbl_y,
  input  logic              i_dbl_finished,
  input  logic [DATA_W-1:0] i_dbl_x,
  input  logic [DATA_W-1:0] i_dbl_y,
  output logic              o_add_start,
  output logic [DATA_W-1:0] o_add_x1,
  output logic [DATA_W-1:0] o_add_y1,
  output logic [DATA_W-1:0] o_add_x2,
  output logic [DATA_W-1:0] o_add_y2,
  input  logic              i_add_finished,
  input  logic [DATA_W-1:0] i_add_x,
  input  logic [DATA_W-1:0] i_add_y
);

  localparam int unsigned       IDX_W    = (KEY_W > 1) ? $clog2(KEY_W) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(KEY_W - 1);
  localparam logic [DATA_W-1:0] INF      = '1;

  state_e            state_q;
  logic [KEY_W-1:0]  k_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] q_x_q, q_y_q, g_x_q, g_y_q;
  logic              dbl_as_add_q;
`ifdef SCALAR_MULT_CONST_TIME_EN
  logic              add_commit_q;
`endif

  logic k_bit_c;
  logic q_inf_c, same_x_c, same_y_c;

  assign k_bit_c = k_q[idx_q];

  ecc_point_cmp #(.DATA_W(DATA_W)) u_cmp (
    .q_x_i    (q_x_q),
    .q_y_i    (q_y_q),
    .g_x_i    (g_x_q),
    .g_y_i    (g_y_q),
    .is_inf_o (q_inf_c),
    .same_x_o (same_x_c),
    .same_y_o (same_y_c)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      idx_q        <= IDX_LAST;
      q_x_q        <= '0;
      q_y_q        <= '0;
      g_x_q        <= '0;
      g_y_q        <= '0;
      dbl_as_add_q <= 1'b0;
`ifdef SCALAR_MULT_CONST_TIME_EN
      add_commit_q <= 1'b0;
`endif
      o_busy       <= 1'b0;
      o_finished   <= 1'b0;
      o_rx         <= '0;
      o_ry         <= '0;
      o_dbl_start  <= 1'b0;
      o_dbl_x      <= '0;
      o_dbl_y      <= '0;
      o_add_start  <= 1'b0;
      o_add_x1     <= '0;
      o_add_y1     <= '0;
      o_add_x2     <= '0;
      o_add_y2     <= '0;
    end else begin
      o_dbl_start <= 1'b0;
      o_add_start <= 1'b0;
      o_finished  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            k_q          <= i_k;
            g_x_q        <= i_gx;
            g_y_q        <= i_gy;
            idx_q        <= IDX_LAST;
            q_x_q        <= INF;
            q_y_q        <= INF;
            dbl_as_add_q <= 1'b0;
            o_busy       <= 1'b1;
`ifdef SCALAR_MULT_CONST_TIME_EN
            state_q      <= ST_DBL_REQ;
`else
            state_q      <= ST_SCAN;
`endif
          end
        end
        // Leading-zero skip: the first set bit loads Q = G without an engine call.
        ST_SCAN: begin
          if (k_bit_c) begin
            q_x_q   <= g_x_q;
            q_y_q   <= g_y_q;
            state_q <= ST_NEXT;
          end else if (idx_q == '0) begin
            state_q <= ST_DONE;
          end else begin
            idx_q <= idx_q - IDX_W'(1);
          end
        end
        ST_NEXT: begin
          if (idx_q == '0) begin
            state_q <= ST_DONE;
          end else begin
            idx_q   <= idx_q - IDX_W'(1);
            state_q <= ST_DBL_REQ;
          end
        end
        ST_DBL_REQ: begin
          o_dbl_start <= 1'b1;
          o_dbl_x     <= q_x_q;
          o_dbl_y     <= q_y_q;
          state_q     <= ST_DBL_WAIT;
        end
        ST_DBL_WAIT: begin
          if (i_dbl_finished) begin
            q_x_q        <= i_dbl_x;
            q_y_q        <= i_dbl_y;
            dbl_as_add_q <= 1'b0;
`ifdef SCALAR_MULT_CONST_TIME_EN
            state_q      <= dbl_as_add_q ? ST_ADD_REQ : ST_ADD_CHK;
`else
            if (dbl_as_add_q)  state_q <= ST_NEXT;
            else if (k_bit_c)  state_q <= ST_ADD_CHK;
            else               state_q <= ST_NEXT;
`endif
          end
        end
`ifdef SCALAR_MULT_CONST_TIME_EN
        // Exceptions resolve here only for set bits; the add engine still runs afterwards.
        ST_ADD_CHK: begin
          add_commit_q <= 1'b0;
          state_q      <= ST_ADD_REQ;
          if (k_bit_c) begin
            if (q_inf_c) begin
              q_x_q <= g_x_q;
              q_y_q <= g_y_q;
            end else if (same_x_c && same_y_c) begin
              dbl_as_add_q <= 1'b1;
              state_q      <= ST_DBL_REQ;
            end else if (same_x_c) begin
              q_x_q <= INF;
              q_y_q <= INF;
            end else begin
              add_commit_q <= 1'b1;
            end
          end
        end
`else
        ST_ADD_CHK: begin
          state_q <= ST_NEXT;
          if (q_inf_c) begin
            q_x_q <= g_x_q;
            q_y_q <= g_y_q;
          end else if (same_x_c && same_y_c) begin
            dbl_as_add_q <= 1'b1;
            state_q      <= ST_DBL_REQ;
          end else if (same_x_c) begin
            q_x_q <= INF;
            q_y_q <= INF;
          end else begin
            state_q <= ST_ADD_REQ;
          end
        end
`endif
        ST_ADD_REQ: begin
          o_add_start <= 1'b1;
          o_add_x1    <= q_x_q;
          o_add_y1    <= q_y_q;
          o_add_x2    <= g_x_q;
          o_add_y2    <= g_y_q;
          state_q     <= ST_ADD_WAIT;
        end
        ST_ADD_WAIT: begin
          if (i_add_finished) begin
`ifdef SCALAR_MULT_CONST_TIME_EN
            if (add_commit_q) begin
              q_x_q <= i_add_x;
              q_y_q <= i_add_y;
            end
`else
            q_x_q <= i_add_x;
            q_y_q <= i_add_y;
`endif
            state_q <= ST_NEXT;
          end
        end
        ST_DONE: begin
          o_rx       <= q_x_q;
          o_ry       <= q_y_q;
          o_finished <= 1'b1;
          o_busy     <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Directed bench for scalar_mult_ctrl on y^2 = x^3+2x+2 mod 17, G = (5,1), with 7-cycle behavioral engines.
module tb_scalar_mult_ctrl;
  import ecc_pkg::*;

  localparam int unsigned KW  = KEY_W_DEF;
  localparam int unsigned DW  = DATA_W_DEF;
  localparam int          LAT = 7;
  localparam int          TMO = 20000;
  localparam logic [DW-1:0] INF = '1;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_start = 1'b0;
  logic [KW-1:0] i_k = '0;
  logic [DW-1:0] i_gx = DW'(5);
  logic [DW-1:0] i_gy = DW'(1);
  logic          o_busy, o_finished;
  logic [DW-1:0] o_rx, o_ry;
  logic          o_dbl_start;
  logic [DW-1:0] o_dbl_x, o_dbl_y;
  logic          i_dbl_finished = 1'b0;
  logic [DW-1:0] i_dbl_x = '0, i_dbl_y = '0;
  logic          o_add_start;
  logic [DW-1:0] o_add_x1, o_add_y1, o_add_x2, o_add_y2;
  logic          i_add_finished = 1'b0;
  logic [DW-1:0] i_add_x = '0, i_add_y = '0;

  int n_chk = 0, n_pass = 0;
  int dbl_cnt = 0, add_cnt = 0, fin_cnt = 0;

  scalar_mult_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_k(i_k), .i_gx(i_gx), .i_gy(i_gy),
    .o_busy(o_busy), .o_finished(o_finished), .o_rx(o_rx), .o_ry(o_ry),
    .o_dbl_start(o_dbl_start), .o_dbl_x(o_dbl_x), .o_dbl_y(o_dbl_y),
    .i_dbl_finished(i_dbl_finished), .i_dbl_x(i_dbl_x), .i_dbl_y(i_dbl_y),
    .o_add_start(o_add_start), .o_add_x1(o_add_x1), .o_add_y1(o_add_y1),
    .o_add_x2(o_add_x2), .o_add_y2(o_add_y2),
    .i_add_finished(i_add_finished), .i_add_x(i_add_x), .i_add_y(i_add_y)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int md(input int a);
    int r;
    r = a % 17;
    return (r < 0) ? r + 17 : r;
  endfunction

  function automatic int inv(input int a);
    int r;
    r = 1;
    for (int i = 0; i < 15; i++) r = md(r * a);
    return r;
  endfunction

  task automatic ec_dbl(input logic [DW-1:0] x, input logic [DW-1:0] y,
                        output logic [DW-1:0] rx, output logic [DW-1:0] ry);
    int xi, yi, l, x3;
    if (x == INF || y == '0) begin
      rx = INF; ry = INF;
    end else begin
      xi = int'(x[7:0]); yi = int'(y[7:0]);
      l  = md(md(3 * xi * xi + 2) * inv(md(2 * yi)));
      x3 = md(l * l - 2 * xi);
      rx = DW'(x3);
      ry = DW'(md(l * (xi - x3) - yi));
    end
  endtask

  task automatic ec_add(input logic [DW-1:0] x1, input logic [DW-1:0] y1,
                        input logic [DW-1:0] x2, input logic [DW-1:0] y2,
                        output logic [DW-1:0] rx, output logic [DW-1:0] ry);
    int a1, b1, a2, b2, l, x3;
    if (x1 == INF) begin
      rx = x2; ry = y2;
    end else if (x2 == INF) begin
      rx = x1; ry = y1;
    end else if (x1 == x2) begin
      if (y1 == y2) ec_dbl(x1, y1, rx, ry);
      else begin rx = INF; ry = INF; end
    end else begin
      a1 = int'(x1[7:0]); b1 = int'(y1[7:0]); a2 = int'(x2[7:0]); b2 = int'(y2[7:0]);
      l  = md(md(b2 - b1) * inv(md(a2 - a1)));
      x3 = md(l * l - a1 - a2);
      rx = DW'(x3);
      ry = DW'(md(l * (a1 - x3) - b1));
    end
  endtask

  always @(negedge i_clk) begin
    if (o_dbl_start) dbl_cnt++;
    if (o_add_start) add_cnt++;
    if (o_finished)  fin_cnt++;
  end

  // Double engine; keeps running through a controller reset so a stale finish can arrive.
  initial begin
    logic [DW-1:0] rx, ry;
    forever begin
      @(negedge i_clk);
      if (o_dbl_start) begin
        ec_dbl(o_dbl_x, o_dbl_y, rx, ry);
        repeat (LAT - 1) @(negedge i_clk);
        i_dbl_x = rx; i_dbl_y = ry; i_dbl_finished = 1'b1;
        @(negedge i_clk);
        i_dbl_finished = 1'b0;
      end
    end
  end

  initial begin
    logic [DW-1:0] rx, ry;
    forever begin
      @(negedge i_clk);
      if (o_add_start) begin
        ec_add(o_add_x1, o_add_y1, o_add_x2, o_add_y2, rx, ry);
        repeat (LAT - 1) @(negedge i_clk);
        i_add_x = rx; i_add_y = ry; i_add_finished = 1'b1;
        @(negedge i_clk);
        i_add_finished = 1'b0;
      end
    end
  end

  // exp_dbl < 0 skips the engine-count checks; counts and cycles are returned for comparison.
  task automatic run_mult(input string tag, input logic [KW-1:0] k,
                          input logic [DW-1:0] ex, input logic [DW-1:0] ey,
                          input int exp_dbl, input int exp_add,
                          output int cyc, output int nd, output int na);
    int d0, a0, f0;
    bit done;
    d0 = dbl_cnt; a0 = add_cnt; f0 = fin_cnt; done = 1'b0; cyc = 0;
    @(negedge i_clk);
    i_k = k; i_start = 1'b1;
    while (!done && cyc < TMO) begin
      @(negedge i_clk);
      cyc++;
      if (cyc == 1) begin
        i_start = 1'b0;
        check({tag, " busy"}, DW'(o_busy), DW'(1));
      end
      done = o_finished;
    end
    check({tag, " done"}, DW'(done), DW'(1));
    check({tag, " rx"}, o_rx, ex);
    check({tag, " ry"}, o_ry, ey);
    @(negedge i_clk);
    check({tag, " fin_pulse"}, DW'(o_finished), DW'(0));
    check({tag, " fin_count"}, DW'(fin_cnt - f0), DW'(1));
    nd = dbl_cnt - d0;
    na = add_cnt - a0;
    if (exp_dbl >= 0) begin
      check({tag, " dbl_count"}, DW'(nd), DW'(exp_dbl));
      check({tag, " add_count"}, DW'(na), DW'(exp_add));
    end
  endtask

  initial begin
    int cyc, nd, na;
    int cyc3, nd3, na3;
    int d0, f0, w;
    repeat (3) @(negedge i_clk);
    check("rst rx", o_rx, '0);
    check("rst busy", DW'(o_busy), DW'(0));
    check("rst finished", DW'(o_finished), DW'(0));
    check("rst dbl_start", DW'(o_dbl_start), DW'(0));
    check("rst add_start", DW'(o_add_start), DW'(0));
    i_rst = 1'b0;
    @(negedge i_clk);

`ifdef SCALAR_MULT_CONST_TIME_EN
    run_mult("ct k3", KW'(3), DW'(10), DW'(6), KW, KW, cyc3, nd3, na3);
    run_mult("ct k9", KW'(9), DW'(7), DW'(6), KW, KW, cyc, nd, na);
    check("ct cycles equal", DW'(cyc), DW'(cyc3));
    check("ct dbl equal", DW'(nd), DW'(nd3));
    check("ct add equal", DW'(na), DW'(na3));
    run_mult("ct k2", KW'(2), DW'(6), DW'(3), KW, KW, cyc, nd, na);
`else
    run_mult("k1", KW'(1), DW'(5), DW'(1), 0, 0, cyc, nd, na);
    check("k1 cycles", DW'(cyc), DW'(KW + 3));
    run_mult("k3", KW'(3), DW'(10), DW'(6), 1, 1, cyc, nd, na);
    run_mult("k19", KW'(19), INF, INF, 4, 1, cyc, nd, na);
    run_mult("k0", KW'(0), INF, INF, 0, 0, cyc, nd, na);
    check("k0 cycles", DW'(cyc), DW'(KW + 2));
    run_mult("k20", KW'(20), DW'(5), DW'(1), 4, 1, cyc, nd, na);
    run_mult("k21", KW'(21), DW'(6), DW'(3), 5, 1, cyc, nd, na);

    // Abort k=9 during its second double wait.
    d0 = dbl_cnt;
    @(negedge i_clk);
    i_k = KW'(9); i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    w = 0;
    while (dbl_cnt - d0 < 2 && w < 500) begin
      @(negedge i_clk);
      w++;
    end
    check("abort reached dbl2", DW'(dbl_cnt - d0), DW'(2));
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("abort busy", DW'(o_busy), DW'(0));
    check("abort rx", o_rx, '0);
    check("abort dbl_x", o_dbl_x, '0);
    d0 = dbl_cnt; f0 = fin_cnt;
    repeat (12) @(negedge i_clk);
    check("stale busy", DW'(o_busy), DW'(0));
    check("stale dbl_start", DW'(dbl_cnt - d0), DW'(0));
    check("stale finished", DW'(fin_cnt - f0), DW'(0));
    run_mult("k2", KW'(2), DW'(6), DW'(3), 1, 0, cyc, nd, na);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/scalar_mult_ctrl.md
Name: scalar_mult_ctrl

Overview:
- Sequencing controller for elliptic-curve scalar multiplication R = k·G using left-to-right (MSB-first) double-and-add.
- Drives one external point-double engine and one external point-add engine through start/finish handshakes, and holds the accumulator point Q.
- Sits above the point-arithmetic units and below the protocol top level. Performs no field arithmetic; uses only comparisons and muxing.
- Point at infinity is encoded as x = all-ones (y is don't-care, driven as all-ones).

Parameters:
- KEY_W, 256, scalar width in bits.
- DATA_W, 256, coordinate width in bits.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  one-cycle start pulse; sampled only in IDLE.
- i_k  in  KEY_W  scalar; latched on i_start.
- i_gx, i_gy  in  DATA_W  base point G; latched on i_start.
- o_busy  out  1  high from the cycle after accepted start until DONE.
- o_finished  out  1  one-cycle pulse; result valid and held until the next accepted start.
- o_rx, o_ry  out  DATA_W  result point.
- o_dbl_start  out  1  one-cycle pulse to the double engine.
- o_dbl_x, o_dbl_y  out  DATA_W  double operand (= Q), stable until i_dbl_finished.
- i_dbl_finished  in  1  double-engine done pulse.
- i_dbl_x, i_dbl_y  in  DATA_W  double result.
- o_add_start  out  1  one-cycle pulse to the add engine.
- o_add_x1, o_add_y1, o_add_x2, o_add_y2  out  DATA_W  add operands (Q, G).
- i_add_finished  in  1  add-engine done pulse.
- i_add_x, i_add_y  in  DATA_W  add result.

Behaviour:
- Reset: state IDLE; all outputs 0; Q, G and k registers 0; bit index = KEY_W-1. Reset mid-operation aborts immediately. Any late engine finish pulse arriving in IDLE is ignored.
- States: IDLE, SCAN, DBL_REQ, DBL_WAIT, ADD_CHK, ADD_REQ, ADD_WAIT, NEXT, DONE.
- IDLE: on i_start, latch k, G and idx = KEY_W-1; set Q = infinity; go to SCAN. i_start in any other state is ignored.
- SCAN (leading-zero skip): one bit per cycle.
  - k[idx] = 1: Q := G, go to NEXT with no engine call.
  - k[idx] = 0 and idx = 0: go to DONE (k = 0 gives infinity).
  - Otherwise idx--.
- NEXT: if idx = 0, go to DONE; else idx--, go to DBL_REQ.
- DBL_REQ: assert o_dbl_start for exactly 1 cycle, go to DBL_WAIT.
- DBL_WAIT: on i_dbl_finished, Q := (i_dbl_x, i_dbl_y). If k[idx] = 1, go to ADD_CHK; else go to NEXT.
- ADD_CHK (exceptional cases, one cycle, no engine call):
  - Q = infinity: Q := G.
  - Qx = Gx and Qy = Gy: go to DBL_REQ-style doubling via the double engine; the result is committed and then goes to NEXT (sub-flag marks "double-as-add").
  - Qx = Gx and Qy ≠ Gy: Q := infinity.
  - Otherwise: go to ADD_REQ.
  - All non-engine branches go to NEXT.
- ADD_REQ / ADD_WAIT: same pulse/wait rule; on i_add_finished, Q := add result, go to NEXT.
- DONE: o_rx/o_ry := Q; o_finished = 1 for one cycle; o_busy = 0; go to IDLE.
- Finish pulses received outside their WAIT state are ignored.
- Engine operand outputs are registered and change only in REQ/CHK states.
- Engine latencies are unbounded; there is no timeout.
- Latency: k = 1 takes KEY_W+3 cycles with no engine calls; otherwise cycles ≈ SCAN + Σ(engine latency + 2 per request).

Optional Feature:
- Macro SCALAR_MULT_CONST_TIME_EN.
- Defined:
  - SCAN is removed; every one of the KEY_W bits performs a double, then an add.
  - The add result is committed only when k[idx] = 1; otherwise it is discarded (dummy add). The engines are still started, so the engine-call sequence is independent of k.
  - The infinity/equal-point cases still resolve in ADD_CHK, but ADD_REQ/ADD_WAIT are executed anyway and the result is discarded.
- Undefined: behaviour as above.

Decomposition:
- Package ecc_pkg:
  - DATA_W/KEY_W defaults.
  - INF_X constant (all-ones).
  - State enum typedef.
  - Point struct typedef {x, y}.
- One sub-module is natural: ecc_point_cmp, combinational, giving is_inf / same_x / same_y flags for Q vs G.

Test Plan (curve y² = x³+2x+2 mod 17, G = (5,1), order 19; bench engines are behavioral with 7-cycle latency):
- k=1 -> (5,1); zero o_dbl_start and zero o_add_start pulses; o_finished pulses once.
- k=3 -> (10,6); exactly 1 double and 1 add.
- k=19 -> o_rx = all-ones (infinity). 18G = (5,16) triggers the Qx = Gx, Qy ≠ Gy path; 4 doubles, 1 engine add.
- k=0 -> infinity after KEY_W SCAN cycles; no engine pulses. k=20 -> (5,1).
- k=9 -> (7,6). Assert i_rst during the second DBL_WAIT, then release: outputs 0, IDLE. A stale i_dbl_finished is ignored. A subsequent k=2 -> (6,3).
- With SCALAR_MULT_CONST_TIME_EN: k=3 and k=9 -> correct results, and both runs have identical o_dbl_start/o_add_start pulse counts and total cycles.
